// File: rtl/custom_axi_ip_sched.sv
// Round-robin arbiter sharing one increment engine among NUM_REQ requesters; accept->rsp 3+k cycles.
// Backpressure: a single request is accepted only in IDLE (req_ready_o one-hot); rsp is a 1-cycle strobe.
module custom_axi_ip_sched #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [NUM_REQ-1:0]            rsp_valid_o,
  output logic [DATA_WIDTH-1:0]         rsp_data_o,
  output logic                          rsp_error_o,
  output logic                          eng_start_o,
  output logic [DATA_WIDTH-1:0]         eng_din_o,
  input  logic                          eng_done_i,
  input  logic [DATA_WIDTH-1:0]         eng_dout_i,
  output logic                          busy_o,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id_o,
  output logic [7:0]                    err_count_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t                state;
  logic [IDW-1:0]        rr_ptr;
  logic [TW-1:0]         timer;
  logic [IDW-1:0]        gnt_idx;
  logic [IDW-1:0]        cand;
  logic                  gnt_found;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];
  int                    arb_idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_data_arr[i] = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan from rr_ptr upward with wraparound; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    gnt_data  = '0;
    arb_idx   = 0;
    cand      = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      arb_idx = int'(rr_ptr) + off;
      if (arb_idx >= NUM_REQ) arb_idx = arb_idx - NUM_REQ;
      cand = IDW'(arb_idx);
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
        gnt_data  = req_data_arr[cand];
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (rst_ni && state == ST_IDLE && gnt_found) req_ready_o = NUM_REQ'(1) << gnt_idx;
  end

  assign busy_o = (state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      timer       <= '0;
      eng_din_o   <= '0;
      eng_start_o <= 1'b0;
      grant_id_o  <= '0;
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_error_o <= 1'b0;
      err_count_o <= '0;
    end else begin
      eng_start_o <= 1'b0;
      rsp_valid_o <= '0;
      case (state)
        ST_IDLE: begin
          if (gnt_found) begin
            eng_din_o   <= gnt_data;
            grant_id_o  <= gnt_idx;
            rr_ptr      <= (gnt_idx == IDW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            eng_start_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          timer <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A done coinciding with the last timer value still counts as success.
          if (eng_done_i) begin
            rsp_data_o  <= eng_dout_i;
            rsp_error_o <= 1'b0;
            rsp_valid_o <= NUM_REQ'(1) << grant_id_o;
            state       <= ST_RESP;
          end else if (timer == TW'(TIMEOUT_CYCLES-1)) begin
            rsp_data_o  <= '0;
            rsp_error_o <= 1'b1;
            rsp_valid_o <= NUM_REQ'(1) << grant_id_o;
            if (err_count_o != 8'hFF) err_count_o <= err_count_o + 8'd1;
            state       <= ST_RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
